// File: rtl/storage_access_ctrl.sv
// storage_access_ctrl
//   Front-end controller for a single-port storage array. Rising edges on
//   SW[1] (write), SW[2] (read-next) and SW[3] (clear) are turned into
//   single-cycle storage transactions with auto-incrementing pointers.
//   Read data is registered onto Data_Output.
//
//   Handshake: there is no valid/ready pair on the switch side. A switch
//   edge is accepted only when Busy=0 (FSM in IDLE); edges seen while Busy=1
//   are dropped. On the storage side, Mem_WE is a one-cycle write strobe
//   and Mem_RData is taken one cycle after Mem_Addr is presented.
//
//   Optional build macro: STORAGE_CTRL_DEBOUNCE_EN adds a per-bit debounce
//   filter of DEB_CYCLES cycles between the synchronizer and edge detect.
//
//   dbg_state exposes the FSM state encoding for checkers.
module storage_access_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int DEB_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Data_Input,
    input  logic [6:1]        SW,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_WE,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic [DATA_W-1:0] Data_Output,
    output logic [ADDR_W:0]   Wr_Count,
    output logic              Full,
    output logic              Busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(1 << ADDR_W);

    state_t            state_q;
    state_t            state_d;
    logic              do_clear;
    logic [3:1]        sw_meta;
    logic [3:1]        sw_sync;
    logic [3:1]        sw_level;
    logic [3:1]        sw_level_q;
    logic [3:1]        sw_edge;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   rd_ptr_inc;

    // Reserved switches and the debounce length (unused in the plain build)
    // are deliberately consumed here.
    logic unused_ok;
    assign unused_ok = &{1'b0, SW[6:4], (DEB_CYCLES > 0)};

    // Two-flop synchronizer for the three active switches.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW[3:1];
            sw_sync <= sw_meta;
        end
    end

`ifdef STORAGE_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] deb_cnt [3:1];
    logic [3:1]       sw_filt;

    // Filtered level follows the synchronized level only after it has
    // disagreed for DEB_CYCLES consecutive cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_filt <= '0;
            for (int i = 1; i <= 3; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 1; i <= 3; i++) begin
                if (sw_sync[i] != sw_filt[i]) begin
                    if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                        sw_filt[i] <= sw_sync[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign sw_level = sw_filt;
`else
    assign sw_level = sw_sync;
`endif

    // Previous level for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) sw_level_q <= '0;
        else     sw_level_q <= sw_level;
    end

    assign sw_edge = sw_level & ~sw_level_q;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; clear beats write beats read, losers are dropped.
    always_comb begin
        state_d  = state_q;
        do_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (sw_edge[3]) begin
                    do_clear = 1'b1;
                end else if (sw_edge[1]) begin
                    if (!Full) state_d = WRITE;
                end else if (sw_edge[2]) begin
                    if (Wr_Count != '0) state_d = RD_ISSUE;
                end
            end
            WRITE:    state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign rd_ptr_inc = {1'b0, rd_ptr} + (ADDR_W+1)'(1);

    // Datapath: pointers, counters, address/data registers and read capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            Wr_Count    <= '0;
            Mem_Addr    <= '0;
            Mem_WData   <= '0;
            Data_Output <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (do_clear) begin
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        Wr_Count    <= '0;
                        Data_Output <= '0;
                    end
                    if (state_d == WRITE) begin
                        Mem_WData <= Data_Input;
                        Mem_Addr  <= wr_ptr;
                    end
                    if (state_d == RD_ISSUE) begin
                        Mem_Addr <= rd_ptr;
                    end
                end
                WRITE: begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (Wr_Count != DEPTH_CNT) Wr_Count <= Wr_Count + (ADDR_W+1)'(1);
                end
                RD_WAIT: begin
                    Data_Output <= Mem_RData;
                    if (rd_ptr_inc == Wr_Count) rd_ptr <= '0;
                    else                        rd_ptr <= rd_ptr_inc[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // A WRITE cycle that coincides with reset must not reach the array.
    assign Mem_WE    = (state_q == WRITE) && !RST;
    assign Full      = (Wr_Count == DEPTH_CNT);
    assign Busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_storage_access_ctrl.sv
// Bench for storage_access_ctrl: one ADDR_W=4 and one ADDR_W=2 instance
// share stimulus; each has its own behavioural storage array.
module tb_storage_access_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic [6:1]    sw;

  logic [3:0]    a4;
  logic          we4;
  logic [DW-1:0] wd4, rd4, do4;
  logic [4:0]    cnt4;
  logic          full4, busy4;
  logic [1:0]    st4;

  logic [1:0]    a2;
  logic          we2;
  logic [DW-1:0] wd2, rd2, do2;
  logic [2:0]    cnt2;
  logic          full2, busy2;
  logic [1:0]    st2;

  logic [DW-1:0] mem4 [16];
  logic [DW-1:0] mem2 [4];

  int checks = 0;
  int errors = 0;

  logic [35:0]   exp4_q[$];
  logic [33:0]   exp2_q[$];
  logic [DW-1:0] exp_rd4_q[$];
  logic [DW-1:0] exp_rd2_q[$];

  // reference model state
  int            wc4, wp4, rp4, wc2, wp2, rp2;
  logic [DW-1:0] m4 [16];
  logic [DW-1:0] m2 [4];
  logic [DW-1:0] dexp4, dexp2;

  storage_access_ctrl #(.ADDR_W(4), .DATA_W(DW), .DEB_CYCLES(16)) dut4 (
    .CLK(clk), .RST(rst), .Data_Input(din), .SW(sw),
    .Mem_Addr(a4), .Mem_WE(we4), .Mem_WData(wd4), .Mem_RData(rd4),
    .Data_Output(do4), .Wr_Count(cnt4), .Full(full4), .Busy(busy4),
    .dbg_state(st4)
  );

  storage_access_ctrl #(.ADDR_W(2), .DATA_W(DW), .DEB_CYCLES(16)) dut2 (
    .CLK(clk), .RST(rst), .Data_Input(din), .SW(sw),
    .Mem_Addr(a2), .Mem_WE(we2), .Mem_WData(wd2), .Mem_RData(rd2),
    .Data_Output(do2), .Wr_Count(cnt2), .Full(full2), .Busy(busy2),
    .dbg_state(st2)
  );

  // clock / storage arrays
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we4) mem4[a4] <= wd4;
    rd4 <= mem4[a4];
    if (we2) mem2[a2] <= wd2;
    rd2 <= mem2[a2];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // write monitor: every strobe must match the next expected transaction
  always @(negedge clk) begin
    if (we4 !== 1'b0) begin
      if (exp4_q.size() == 0) check("we4_unexpected", {63'd0, we4}, 64'd0);
      else                    check("we4_txn", {28'd0, a4, wd4}, {28'd0, exp4_q.pop_front()});
    end
    if (we2 !== 1'b0) begin
      if (exp2_q.size() == 0) check("we2_unexpected", {63'd0, we2}, 64'd0);
      else                    check("we2_txn", {30'd0, a2, wd2}, {30'd0, exp2_q.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy4 !== 1'b0 || busy2 !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse(input int b);
    sw[b] = 1'b1;
    repeat ($urandom_range(40, 60)) @(negedge clk);
    sw[b] = 1'b0;
    repeat ($urandom_range(40, 60)) @(negedge clk);
    wait_idle();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt4"}, {59'd0, cnt4}, 64'(wc4));
    check({tag, "_cnt2"}, {61'd0, cnt2}, 64'(wc2));
    check({tag, "_full4"}, {63'd0, full4}, {63'd0, wc4 == 16});
    check({tag, "_full2"}, {63'd0, full2}, {63'd0, wc2 == 4});
  endtask

  task automatic model_clear();
    wc4 = 0; wp4 = 0; rp4 = 0; dexp4 = '0;
    wc2 = 0; wp2 = 0; rp2 = 0; dexp2 = '0;
  endtask

  task automatic model_write(input logic [DW-1:0] v);
    if (wc4 != 16) begin
      exp4_q.push_back({4'(wp4), v});
      m4[wp4] = v; wp4 = (wp4 + 1) % 16; wc4++;
    end
    if (wc2 != 4) begin
      exp2_q.push_back({2'(wp2), v});
      m2[wp2] = v; wp2 = (wp2 + 1) % 4; wc2++;
    end
  endtask

  task automatic do_write(input logic [DW-1:0] v);
    din = v;
    model_write(v);
    pulse(1);
    din = $urandom();
    check_counts("write");
  endtask

  task automatic do_read();
    if (wc4 != 0) begin
      dexp4 = m4[rp4];
      rp4 = (rp4 + 1 == wc4) ? 0 : rp4 + 1;
    end
    if (wc2 != 0) begin
      dexp2 = m2[rp2];
      rp2 = (rp2 + 1 == wc2) ? 0 : rp2 + 1;
    end
    exp_rd4_q.push_back(dexp4);
    exp_rd2_q.push_back(dexp2);
    pulse(2);
    check("read_dout4", {32'd0, do4}, {32'd0, exp_rd4_q.pop_front()});
    check("read_dout2", {32'd0, do2}, {32'd0, exp_rd2_q.pop_front()});
  endtask

  task automatic do_clear();
    model_clear();
    pulse(3);
    check_counts("clear");
    check("clear_dout4", {32'd0, do4}, 64'd0);
  endtask

  // directed sequence
  initial begin
    rst = 1'b1;
    sw  = '0;
    din = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr", {60'd0, a4}, 64'd0);
    check("rst_we", {63'd0, we4}, 64'd0);
    check("rst_wdata", {32'd0, wd4}, 64'd0);
    check("rst_dout", {32'd0, do4}, 64'd0);
    check("rst_cnt", {59'd0, cnt4}, 64'd0);
    check("rst_full", {63'd0, full4}, 64'd0);
    check("rst_busy", {62'd0, busy4, busy2}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // four writes; the small instance becomes full
    for (int i = 0; i < 4; i++) do_write(DW'(i));

    // five reads, read pointer wraps after the fourth
    for (int i = 0; i < 5; i++) do_read();

    // clear, then five writes: the fifth is dropped on the small instance
    do_clear();
    for (int i = 0; i < 5; i++) do_write(32'hA0 + DW'(i));
    do_read();

    // clear and write rising together: clear wins, no write strobe
    din   = 32'hDEAD_BEEF;
    sw[1] = 1'b1;
    sw[3] = 1'b1;
    model_clear();
    repeat (50) @(negedge clk);
    sw[1] = 1'b0;
    sw[3] = 1'b0;
    repeat (50) @(negedge clk);
    wait_idle();
    check_counts("simul");
    check("simul_dout4", {32'd0, do4}, 64'd0);

    // read with nothing stored is ignored
    do_read();
    check("empty_read_busy", {62'd0, busy4, busy2}, 64'd0);

    // reset during the WRITE cycle: no strobe, everything returns to zero
    din   = 32'h1234_5678;
    sw[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (busy4 === 1'b1) break;
    end
    check("abort_busy", {62'd0, busy4, busy2}, 64'd3);
    check("abort_state", {62'd0, st4}, 64'd1);
    rst   = 1'b1;
    sw[1] = 1'b0;
    #1;
    check("abort_we", {62'd0, we4, we2}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_counts("abort");
    check("abort_idle", {62'd0, busy4, busy2}, 64'd0);
    repeat (10) @(negedge clk);

    // recovery after abort
    do_write(32'h0000_0055);
    do_read();

`ifdef STORAGE_CTRL_DEBOUNCE_EN
    // short glitch is filtered out
    din   = 32'h6666_0001;
    sw[1] = 1'b1;
    repeat (10) @(negedge clk);
    sw[1] = 1'b0;
    repeat (60) @(negedge clk);
    wait_idle();
    check_counts("glitch");
    // pulse longer than the window writes once
    din = 32'h6666_0002;
    model_write(din);
    sw[1] = 1'b1;
    repeat (20) @(negedge clk);
    sw[1] = 1'b0;
    repeat (60) @(negedge clk);
    wait_idle();
    check_counts("deb_pulse");
`endif

    repeat (5) @(negedge clk);
    check("pending_writes4", 64'(exp4_q.size()), 64'd0);
    check("pending_writes2", 64'(exp2_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
